// File: rtl/instr_fetch_queue.sv
// Fetch front end: owns the PC, issues word fetches to a 1-cycle-latency
// instruction memory and buffers returned {pc, instruction} pairs in a small
// FIFO toward decode. Redirects from EX flush every younger fetch.
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_insr_o,
  output logic [31:0] out_pc_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic          kill;

  logic          pop;
  logic          push;
  logic [CW:0]   occ_after_pop;

  // Alignment bits of the redirect target are dropped on purpose.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // Handshake, issue and response-accept decisions for this cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    out_valid_o   = 1'b0;
    pop           = 1'b0;
    push          = 1'b0;
    imem_req_o    = 1'b0;
    occ_after_pop = '0;

    out_valid_o   = (count != '0) && !redirect_i;
    pop           = out_valid_o && out_ready_i;
    // Slots committed next cycle: held entries plus the returning word, minus what leaves now.
    occ_after_pop = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    imem_req_o    = !rst_i && !redirect_i && (occ_after_pop < (CW+1)'(DEPTH));
    // A response is kept only if it was not killed and no flush is happening now.
    push          = inflight && !kill && !redirect_i;
  end

  assign imem_addr_o = pc;
  assign out_insr_o  = mem[rd_ptr].insr;
  assign out_pc_o    = mem[rd_ptr].pc;

  // PC, in-flight tracking and FIFO pointer/count state.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_i) begin
      pc       <= {redirect_pc_i[31:2], 2'b00};
      inflight <= 1'b0;
      kill     <= inflight;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req_o;
      kill     <= 1'b0;
      if (imem_req_o) begin
        pc     <= pc + 32'd4;
        req_pc <= pc;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the storage is tiny and the head must read zero after reset, so it is reset too.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{pc: req_pc, insr: imem_rdata_i};
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue: a vector table for the
// reset/streaming/stall behaviour plus hand-written redirect and reset sequences.
module tb_instr_fetch_queue;

  localparam int DEPTH = 2;

  logic        clk_i;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_insr_o;
  logic [31:0] out_pc_o;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_pc;

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [13];

  instr_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_insr_o   (out_insr_o),
    .out_pc_o     (out_pc_o)
  );

  // Clock generation.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Instruction memory content: a fixed function of the word address.
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Instruction memory with 1-cycle read latency; garbage when no request.
  always @(posedge clk_i) begin
    imem_rdata_i <= imem_req_o ? word(imem_addr_o) : 32'hDEAD_BEEF;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i      = 1'b1;
    redirect_i = 1'b0;
    tick();
    tick();
    #3;
    check("rst_req",   {31'b0, imem_req_o},  32'd0);
    check("rst_valid", {31'b0, out_valid_o}, 32'd0);
    check("rst_pc",    out_pc_o,             32'd0);
    check("rst_insr",  out_insr_o,           32'd0);
    tick();
    rst_i = 1'b0;
  endtask

  task automatic run_table(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      out_ready_i = vecs[i].ready;
      #3;
      check($sformatf("vec%0d_req", i), {31'b0, imem_req_o}, {31'b0, vecs[i].exp_req});
      if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), imem_addr_o, vecs[i].exp_addr);
      check($sformatf("vec%0d_valid", i), {31'b0, out_valid_o}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_pc", i), out_pc_o, vecs[i].exp_pc);
        check($sformatf("vec%0d_insr", i), out_insr_o, word(vecs[i].exp_pc));
      end
      tick();
    end
  endtask

  // Streams n cycles with a ready pattern, scoreboarding each popped entry.
  task automatic stream(input string tag, input int n, input int mode, output int pops);
    pops = 0;
    for (int i = 0; i < n; i++) begin
      out_ready_i = (mode == 0) ? 1'b1 : !((i % 7) inside {[2:4]});
      #3;
      check({tag, "_occupancy"}, {31'b0, (dut.count <= DEPTH)}, 32'd1);
      if (out_valid_o && out_ready_i) begin
        check({tag, "_pc"}, out_pc_o, exp_pc);
        check({tag, "_insr"}, out_insr_o, word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      tick();
    end
  endtask

  initial begin
    int pops;
    n_checks = 0;
    n_fail   = 0;
    // Test 1: streaming from reset with decode always ready.
    vecs[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    vecs[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    // Test 2: five stall cycles from reset, then release.
    vecs[5]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[6]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[7]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[10] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[11] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    vecs[12] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};

    rst_i         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    out_ready_i   = 1'b1;
    exp_pc        = 32'h0;

    do_reset();
    run_table(0, 4);
    do_reset();
    run_table(5, 12);

    // Test 3: redirect with a buffered entry and a request in flight.
    do_reset();
    out_ready_i = 1'b0;
    tick();                       // issue 0x0
    tick();                       // issue 0x4, 0x0 written
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    out_ready_i   = 1'b1;
    #3;
    check("t3_redir_req",   {31'b0, imem_req_o},  32'd0);
    check("t3_redir_valid", {31'b0, out_valid_o}, 32'd0);
    tick();
    redirect_i = 1'b0;
    #3;
    check("t3_new_req",   {31'b0, imem_req_o},  32'd1);
    check("t3_new_addr",  imem_addr_o,          32'h0000_0100);
    check("t3_flushed",   {31'b0, out_valid_o}, 32'd0);
    tick();
    exp_pc = 32'h0000_0100;
    stream("t3", 10, 0, pops);
    check("t3_pops", pops, 32'd9);

    // Test 4: back-to-back redirects, the second one wins.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    #3;
    check("t4_r1_req",   {31'b0, imem_req_o},  32'd0);
    check("t4_r1_valid", {31'b0, out_valid_o}, 32'd0);
    tick();
    redirect_pc_i = 32'h0000_0300;
    #3;
    check("t4_r2_req",   {31'b0, imem_req_o},  32'd0);
    tick();
    redirect_i = 1'b0;
    #3;
    check("t4_new_req",  {31'b0, imem_req_o},  32'd1);
    check("t4_new_addr", imem_addr_o,          32'h0000_0300);
    tick();
    exp_pc = 32'h0000_0300;
    stream("t4", 10, 0, pops);
    check("t4_pops", pops, 32'd9);

    // Test 5: stalls and pops on a full FIFO while responses keep arriving.
    stream("t5", 28, 1, pops);
    check("t5_progress", {31'b0, (pops > 10)}, 32'd1);
    stream("t5b", 4, 0, pops);

    // Test 6: one-cycle reset mid-stream with a request in flight.
    rst_i = 1'b1;
    #3;
    check("t6_rst_req", {31'b0, imem_req_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    #3;
    check("t6_valid", {31'b0, out_valid_o}, 32'd0);
    check("t6_pc",    out_pc_o,             32'd0);
    check("t6_insr",  out_insr_o,           32'd0);
    check("t6_req",   {31'b0, imem_req_o},  32'd1);
    check("t6_addr",  imem_addr_o,          32'h0);
    tick();
    exp_pc = 32'h0;
    stream("t6", 8, 0, pops);
    check("t6_pops", pops, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
